mmio_irq_ctrl: RTL and testbench
================================

Name: mmio_irq_ctrl

Overview:
Memory-mapped interrupt controller on the OTTER IOBUS. It collects up to NUM_SRC asynchronous board event sources (debounced buttons, timer tick, etc.), latches rising edges as pending, masks them with an enable register, and sequences a single INTR pulse to the MCU. It then holds further interrupts until the handler writes end-of-interrupt (EOI). It sits in the wrapper between the board peripherals and the MCU INTR input, and returns read data to the wrapper's IOBUS_IN mux.

Parameters:
NUM_SRC, 4, number of interrupt sources (1..16); index 0 is highest priority.
BASE_AD, 32'h11100000, base address of the 16-byte register window.
SYNC_STAGES, 2, synchronizer flops per source (>=2).
PULSE_LEN, 2, INTR high time in CLK cycles (>=1).

Ports:
CLK  in  1  system clock (the MCU clock).
RST  in  1  asynchronous, active-high reset.
IRQ_SRC  in  NUM_SRC  asynchronous event inputs; a rising edge requests service.
IOBUS_ADDR  in  32  MCU bus address.
IOBUS_OUT  in  32  MCU write data.
IOBUS_WR  in  1  MCU write strobe; single cycle, sampled on posedge CLK.
RD_DATA  out  32  combinational read data for the current IOBUS_ADDR.
RD_SEL  out  1  combinational: IOBUS_ADDR is within BASE_AD..BASE_AD+0xC, word-aligned.
INTR  out  1  registered interrupt pulse to the MCU.

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-high.
- Register map. All registers are 32-bit and word-aligned. Bits at or above NUM_SRC read 0 and ignore writes.
  - +0x0 PENDING: read; write-1-to-clear.
  - +0x4 ENABLE: read/write.
  - +0x8 ACTIVE: read-only. Bit31 = in service (state != IDLE). Bits[3:0] = ACTIVE_ID.
  - +0xC EOI: write-only (any data); reads 0.
- Reads of unmapped or unaligned addresses: RD_SEL=0, RD_DATA=0.
- Input path: each source passes through SYNC_STAGES flops plus one edge flop. A synchronized 0->1 transition sets PENDING[i] one cycle later. Edge-to-PENDING latency is SYNC_STAGES+1 cycles.
- PENDING latches regardless of ENABLE. A level held high sets PENDING only once.
- Set/clear collision: a W1C and an edge set on the same bit in the same cycle resolve to set. The same applies to an EOI clear colliding with an edge set.
- ENABLE writes take effect next cycle. Clearing an ENABLE bit does not clear its PENDING bit.
- FSM states: IDLE, ASSERT, SERVICE.
  - IDLE: when (PENDING & ENABLE) != 0, latch ACTIVE_ID = lowest set index, set INTR=1, load the pulse counter with PULSE_LEN-1, go to ASSERT. Detection to INTR high takes 1 cycle.
  - ASSERT: decrement the counter. At 0, INTR=0 and go to SERVICE. INTR stays high for exactly PULSE_LEN cycles.
  - SERVICE: wait for an EOI write. On EOI, clear PENDING[ACTIVE_ID] (subject to set-wins) and go to IDLE. A further request can re-assert INTR no earlier than 1 cycle after returning to IDLE.
- EOI writes in IDLE or ASSERT are ignored.
- A W1C of PENDING[ACTIVE_ID] while in SERVICE does not leave SERVICE; only EOI does.
- ACTIVE_ID is frozen from ASSERT through SERVICE. A higher-priority arrival waits; there is no nesting or preemption.
- Disabling the active source mid-service has no effect on the FSM.
- Reset (async, any state, mid-pulse included): state=IDLE, INTR=0, PENDING=0, ENABLE=0, ACTIVE_ID=0, pulse counter=0, synchronizer and edge flops=0. A source held high through reset release therefore produces no edge.
- RD_DATA and RD_SEL are purely combinational from IOBUS_ADDR and the registers. The wrapper ORs RD_DATA into IOBUS_IN when RD_SEL=1.

Decomposition:
- Shared package otter_mmio_pkg holds:
  - Register offsets: IRQ_PENDING_OFS=0x0, IRQ_ENABLE_OFS=0x4, IRQ_ACTIVE_OFS=0x8, IRQ_EOI_OFS=0xC.
  - Default IRQ base address 32'h11100000, alongside the existing SWITCHES/LEDS/SSEG address constants.
  - Enum irq_state_t {IDLE, ASSERT, SERVICE}.
- Sub-module irq_edge_sync (SYNC_STAGES param), instantiated once per source: synchronizer chain plus a registered rising-edge pulse output.
- Priority encoder and FSM stay in mmio_irq_ctrl.

Test Plan:
- Reset, then read +0x0/+0x4/+0x8 -> all 0x00000000; INTR=0.
- Write ENABLE=0x5, pulse IRQ_SRC[2] -> PENDING=0x4 after 3 cycles; INTR high for exactly 2 cycles starting 1 cycle later; ACTIVE reads 0x80000002. Write EOI -> PENDING=0, ACTIVE=0x00000000.
- ENABLE=0xF, raise IRQ_SRC[3] and IRQ_SRC[1] in the same cycle -> ACTIVE_ID=1. After EOI, second INTR pulse with ACTIVE_ID=3. After second EOI, PENDING=0.
- ENABLE=0x0, pulse IRQ_SRC[0] -> PENDING=0x1, no INTR. Write ENABLE=0x1 -> INTR within 2 cycles. Write 0x1 to PENDING while in SERVICE -> PENDING=0, FSM stays in SERVICE until EOI.
- Collision: in SERVICE with ACTIVE_ID=0, EOI write coincides with a new IRQ_SRC[0] synchronized edge -> PENDING[0] remains 1; INTR re-asserts 1 cycle after entering IDLE.
- Assert RST during ASSERT (INTR=1) -> INTR=0 immediately (asynchronous), all registers 0. Hold IRQ_SRC[1] high across reset release -> no PENDING set.

Source files
------------

// File: rtl/otter_mmio_pkg.sv
// Shared OTTER MMIO definitions: peripheral base addresses, interrupt controller
// register offsets, FSM state type and the priority helper.
package otter_mmio_pkg;

    localparam logic [31:0] SWITCHES_AD = 32'h1100_0000;
    localparam logic [31:0] LEDS_AD     = 32'h1108_0000;
    localparam logic [31:0] SSEG_AD     = 32'h110C_0000;
    localparam logic [31:0] IRQ_BASE_AD = 32'h1110_0000;

    localparam logic [3:0] IRQ_PENDING_OFS = 4'h0;
    localparam logic [3:0] IRQ_ENABLE_OFS  = 4'h4;
    localparam logic [3:0] IRQ_ACTIVE_OFS  = 4'h8;
    localparam logic [3:0] IRQ_EOI_OFS     = 4'hC;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Index of the lowest set request bit; index 0 has the highest priority.
    function automatic logic [3:0] lowest_set(input logic [15:0] req);
        lowest_set = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req[i]) begin
                lowest_set = 4'(i);
            end
        end
    endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// One interrupt source: synchronizer chain, edge flop and a rising-edge pulse
// that is suppressed until the chain holds only post-reset samples.
module irq_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   last_level;
    logic [SYNC_STAGES:0]   arm;

    // Synchronizer chain, previous-level flop and post-reset arming shifter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_chain <= {SYNC_STAGES{1'b0}};
            last_level <= 1'b0;
            arm        <= {(SYNC_STAGES+1){1'b0}};
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], src};
            last_level <= sync_chain[SYNC_STAGES-1];
            arm        <= {arm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // A source already high at reset release has no genuine prior low sample,
    // so no edge is reported until the edge flop holds a post-reset value.
    assign rise = sync_chain[SYNC_STAGES-1] & ~last_level & arm[SYNC_STAGES];

endmodule

// File: rtl/mmio_irq_ctrl.sv
// Memory-mapped interrupt controller: latches source edges as pending, masks them
// with ENABLE and issues one fixed-length INTR pulse per request until EOI.
module mmio_irq_ctrl
    import otter_mmio_pkg::*;
#(
    parameter int          NUM_SRC     = 4,
    parameter logic [31:0] BASE_AD     = IRQ_BASE_AD,
    parameter int          SYNC_STAGES = 2,
    parameter int          PULSE_LEN   = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] IRQ_SRC,
    input  logic [31:0]        IOBUS_ADDR,
    input  logic [31:0]        IOBUS_OUT,
    input  logic               IOBUS_WR,
    output logic [31:0]        RD_DATA,
    output logic               RD_SEL,
    output logic               INTR
);

    localparam int               CNT_W    = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1'b1);

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] clr;
    logic [15:0]        req_ext;
    logic [31:0]        ofs;
    logic               in_window;
    logic               wr_pending;
    logic               wr_enable;
    logic               wr_eoi;
    irq_state_t         state;
    logic [3:0]         active_id;
    logic [CNT_W-1:0]   pulse_cnt;
    logic               unused_wdata;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_src
            irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
                .clk  (CLK),
                .rst  (RST),
                .src  (IRQ_SRC[g]),
                .rise (rise[g])
            );
        end
    endgenerate

    assign ofs        = IOBUS_ADDR - BASE_AD;
    assign in_window  = (ofs[31:4] == 28'd0) && (ofs[1:0] == 2'b00);
    assign wr_pending = IOBUS_WR && in_window && (ofs[3:0] == IRQ_PENDING_OFS);
    assign wr_enable  = IOBUS_WR && in_window && (ofs[3:0] == IRQ_ENABLE_OFS);
    assign wr_eoi     = IOBUS_WR && in_window && (ofs[3:0] == IRQ_EOI_OFS);
    assign req_ext    = 16'(pending & enable);

    assign unused_wdata = ^IOBUS_OUT[31:NUM_SRC];

    // Pending clear mask from W1C writes and from EOI of the active source
    always_comb begin
        clr = {NUM_SRC{1'b0}};
        if (wr_pending) begin
            clr = IOBUS_OUT[NUM_SRC-1:0];
        end else begin
            clr = {NUM_SRC{1'b0}};
        end
        if ((state == SERVICE) && wr_eoi) begin
            clr = clr | (ONE_HOT0 << active_id);
        end else begin
            clr = clr;
        end
    end

    // PENDING and ENABLE registers; a same-cycle edge wins over any clear
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending <= {NUM_SRC{1'b0}};
            enable  <= {NUM_SRC{1'b0}};
        end else begin
            pending <= (pending & ~clr) | rise;
            if (wr_enable) begin
                enable <= IOBUS_OUT[NUM_SRC-1:0];
            end
        end
    end

    // Interrupt sequencer: one INTR pulse per request, held off until EOI
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            INTR      <= 1'b0;
            active_id <= 4'd0;
            pulse_cnt <= {CNT_W{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    if (req_ext != 16'd0) begin
                        active_id <= lowest_set(req_ext);
                        INTR      <= 1'b1;
                        pulse_cnt <= CNT_LOAD;
                        state     <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (pulse_cnt == {CNT_W{1'b0}}) begin
                        INTR  <= 1'b0;
                        state <= SERVICE;
                    end else begin
                        pulse_cnt <= pulse_cnt - CNT_W'(1);
                    end
                end
                SERVICE: begin
                    if (wr_eoi) begin
                        active_id <= 4'd0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    INTR  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Combinational read mux; EOI and anything outside the window read as zero
    always_comb begin
        RD_SEL  = in_window;
        RD_DATA = 32'd0;
        if (in_window) begin
            case (ofs[3:0])
                IRQ_PENDING_OFS: RD_DATA = 32'(pending);
                IRQ_ENABLE_OFS:  RD_DATA = 32'(enable);
                IRQ_ACTIVE_OFS:  RD_DATA = {(state != IDLE), 27'd0, active_id};
                default:         RD_DATA = 32'd0;
            endcase
        end else begin
            RD_DATA = 32'd0;
        end
    end

endmodule

// File: tb/tb_mmio_irq_ctrl.sv
// Scoreboard bench for mmio_irq_ctrl: directed scenarios plus random traffic,
// predicted by a behavioural register/interrupt model.
module tb_mmio_irq_ctrl;

    localparam int          NUM_SRC     = 4;
    localparam int          SYNC_STAGES = 2;
    localparam int          PULSE_LEN   = 2;
    localparam logic [31:0] BASE        = 32'h1110_0000;
    localparam int          MASK        = (1 << NUM_SRC) - 1;

    logic               CLK = 1'b0;
    logic               RST;
    logic [NUM_SRC-1:0] IRQ_SRC;
    logic [31:0]        IOBUS_ADDR;
    logic [31:0]        IOBUS_OUT;
    logic               IOBUS_WR;
    logic [31:0]        RD_DATA;
    logic               RD_SEL;
    logic               INTR;

    mmio_irq_ctrl #(
        .NUM_SRC(NUM_SRC), .BASE_AD(BASE), .SYNC_STAGES(SYNC_STAGES), .PULSE_LEN(PULSE_LEN)
    ) dut (
        .CLK(CLK), .RST(RST), .IRQ_SRC(IRQ_SRC), .IOBUS_ADDR(IOBUS_ADDR),
        .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR), .RD_DATA(RD_DATA),
        .RD_SEL(RD_SEL), .INTR(INTR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        intr;
        logic        sel;
        logic [31:0] data;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: phase 0 = waiting, 1 = pulsing, 2 = in service
    int m_pending, m_enable, m_id, m_left, m_phase;
    int hist[$];

    function automatic bit mapped(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'd12) && ((a % 32'd4) == 32'd0);
    endfunction

    function automatic int lowest(input int v);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (((v >> i) & 1) != 0) return i;
        end
        return 0;
    endfunction

    function automatic exp_t predict(input logic [31:0] a);
        exp_t e;
        e.addr = a;
        e.intr = (m_phase == 1);
        e.sel  = mapped(a);
        e.data = 32'd0;
        if (e.sel) begin
            case (a - BASE)
                32'd0:   e.data = m_pending;
                32'd4:   e.data = m_enable;
                32'd8:   e.data = (m_phase != 0 ? 32'h8000_0000 : 32'd0) | m_id;
                default: e.data = 32'd0;
            endcase
        end
        return e;
    endfunction

    task automatic model_reset();
        m_pending = 0; m_enable = 0; m_id = 0; m_left = 0; m_phase = 0;
        hist.delete();
    endtask

    // Advance the model across one rising clock edge
    task automatic model_edge(input bit rst, input int src, input logic [31:0] addr,
                              input bit wr, input logic [31:0] data);
        int rise = 0;
        int clr  = 0;
        int old_pend = m_pending;
        int old_en   = m_enable;
        bit hit;
        logic [31:0] ofs;
        if (rst) begin
            model_reset();
            return;
        end
        // an edge needs a genuine post-reset low sample before the high one
        if (hist.size() > SYNC_STAGES)
            rise = hist[SYNC_STAGES-1] & ~hist[SYNC_STAGES] & MASK;
        hit = wr && mapped(addr);
        ofs = addr - BASE;
        if (hit && ofs == 32'd0) clr = data & MASK;
        if (hit && ofs == 32'd4) m_enable = data & MASK;
        case (m_phase)
            0: if ((old_pend & old_en) != 0) begin
                   m_id = lowest(old_pend & old_en);
                   m_phase = 1;
                   m_left = PULSE_LEN;
               end
            1: begin
                   m_left--;
                   if (m_left == 0) m_phase = 2;
               end
            default: if (hit && ofs == 32'd12) begin
                   clr |= (1 << m_id);
                   m_phase = 0;
                   m_id = 0;
               end
        endcase
        m_pending = (old_pend & ~clr) | rise;
        hist.push_front(src & MASK);
        if (hist.size() > SYNC_STAGES + 1) void'(hist.pop_back());
    endtask

    task automatic cycle(input bit rst, input int src, input logic [31:0] addr,
                         input bit wr, input logic [31:0] data);
        RST = rst;
        IRQ_SRC = src[NUM_SRC-1:0];
        IOBUS_ADDR = addr;
        IOBUS_WR = wr;
        IOBUS_OUT = data;
        if (rst) model_reset();
        sb.push_back(predict(addr));
        @(posedge CLK);
        model_edge(rst, src, addr, wr, data);
        #1;
    endtask

    task automatic idle(input int n, input int src, input logic [31:0] addr);
        for (int i = 0; i < n; i++) cycle(1'b0, src, addr, 1'b0, 32'd0);
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued prediction
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            vectors++;
            if (INTR !== mon_e.intr || RD_SEL !== mon_e.sel || RD_DATA !== mon_e.data) begin
                miscompares++;
                $display("FAIL outputs @%0t addr=%h: got INTR=%b RD_SEL=%b RD_DATA=%h, expected INTR=%b RD_SEL=%b RD_DATA=%h",
                         $time, mon_e.addr, INTR, RD_SEL, RD_DATA, mon_e.intr, mon_e.sel, mon_e.data);
            end
        end
    end

    initial begin
        int src;
        bit rst;
        bit wr;
        logic [31:0] addr;
        logic [31:0] data;

        RST = 1'b1; IRQ_SRC = '0; IOBUS_ADDR = 32'd0; IOBUS_OUT = 32'd0; IOBUS_WR = 1'b0;
        model_reset();
        @(posedge CLK); #1;
        cycle(1'b1, 0, BASE, 1'b0, 32'd0);
        cycle(1'b1, 0, BASE + 32'd8, 1'b0, 32'd0);

        // reset state of every register
        idle(1, 0, BASE);
        idle(1, 0, BASE + 32'd4);
        idle(1, 0, BASE + 32'd8);
        idle(1, 0, BASE + 32'd12);

        // ENABLE=0x5, pulse source 2, watch the pulse, then EOI
        cycle(1'b0, 0, BASE + 32'd4, 1'b1, 32'h5);
        idle(2, 4, BASE);
        idle(2, 0, BASE);
        idle(5, 0, BASE + 32'd8);
        cycle(1'b0, 0, BASE + 32'd12, 1'b1, 32'hDEAD_BEEF);
        idle(1, 0, BASE);
        idle(1, 0, BASE + 32'd8);

        // sources 3 and 1 together: priority, then second pulse after EOI
        cycle(1'b0, 0, BASE + 32'd4, 1'b1, 32'hF);
        idle(2, 10, BASE + 32'd8);
        idle(6, 0, BASE + 32'd8);
        cycle(1'b0, 0, BASE + 32'd12, 1'b1, 32'd0);
        idle(6, 0, BASE + 32'd8);
        cycle(1'b0, 0, BASE + 32'd12, 1'b1, 32'd0);
        idle(2, 0, BASE);

        // pending while disabled, late enable, W1C in service
        cycle(1'b0, 0, BASE + 32'd4, 1'b1, 32'h0);
        idle(2, 1, BASE);
        idle(4, 0, BASE);
        cycle(1'b0, 0, BASE + 32'd4, 1'b1, 32'h1);
        idle(5, 0, BASE + 32'd8);
        cycle(1'b0, 0, BASE, 1'b1, 32'h1);
        idle(3, 0, BASE + 32'd8);

        // EOI colliding with a new source-0 edge; source 0 is low by now
        idle(1, 1, BASE);
        idle(1, 1, BASE + 32'd8);
        cycle(1'b0, 1, BASE + 32'd12, 1'b1, 32'd0);
        idle(4, 1, BASE);
        idle(3, 0, BASE + 32'd8);
        cycle(1'b0, 0, BASE + 32'd12, 1'b1, 32'd0);
        idle(2, 0, BASE);

        // reset mid-pulse with source 1 held high across release
        cycle(1'b0, 0, BASE + 32'd4, 1'b1, 32'h5);
        idle(4, 4, BASE + 32'd8);
        cycle(1'b1, 2, BASE + 32'd8, 1'b0, 32'd0);
        cycle(1'b1, 2, BASE, 1'b0, 32'd0);
        idle(8, 2, BASE);
        idle(1, 2, BASE + 32'd4);

        // randomized traffic
        src = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) src ^= (1 << $urandom_range(0, NUM_SRC - 1));
            case ($urandom_range(0, 8))
                0:       addr = BASE;
                1:       addr = BASE + 32'd4;
                2:       addr = BASE + 32'd8;
                3, 4:    addr = BASE + 32'd12;
                5:       addr = BASE + 32'd2;
                6:       addr = BASE + 32'd16;
                7:       addr = BASE - 32'd4;
                default: addr = $urandom;
            endcase
            wr   = ($urandom_range(0, 3) == 0);
            data = $urandom;
            rst  = ($urandom_range(0, 599) == 0);
            cycle(rst, src, addr, wr, data);
        end
        idle(2, 0, BASE);

        repeat (2) @(negedge CLK);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard-drain: got %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
